lsu_mem_port: RTL and testbench
===============================

# lsu_mem_port

Load/store unit sitting between the core's memory stage and the word-addressed data memory (256×32, asynchronous read, synchronous write, no byte enables). Accepts RISC-V load/store requests, drives the memory's WE/Address/WD port and consumes its RD output. Extracts and extends bytes and halfwords on loads. Performs read-modify-write for SB/SH, because the memory writes whole words only.

## Interface
- No parameters; data and address width are fixed at 32.
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  1  core presents a request
- req_ready  out  1  block can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data; low byte/halfword used for SB/SH
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  load result; 0 when resp_valid=0 or for stores
- resp_fault  out  1  qualified by resp_valid
- mem_WE  out  1  memory write enable
- mem_Address  out  32  word-aligned address; bits [1:0] always 0
- mem_WD  out  32  memory write data
- mem_RD  in  32  memory read data, combinational from mem_Address

## Operation
- The request is accepted when req_valid && req_ready at a rising edge. Address, we, funct3 and wdata are latched into internal registers.
- States:
  - IDLE: wait for a request.
  - LOAD: one cycle. resp_valid=1. resp_rdata is extracted from mem_RD at the latched word. Return to IDLE.
  - MERGE: one cycle. mem_RD is read, and the byte/halfword lane selected by addr[1:0]/addr[1] is replaced with wdata. The merged word is registered. Go to WRITE.
  - WRITE: one cycle. mem_WE=1, mem_WD = wdata (SW) or the merged word. resp_valid=1. Return to IDLE.
  - FAULT: one cycle. resp_valid=1, resp_fault=1, no memory access. Return to IDLE.
- Transitions out of IDLE on accept:
  - Invalid funct3 (011, 110, 111, or 100/101 with req_we=1): go to FAULT.
  - Misaligned access with MISALIGN_TRAP_EN defined: go to FAULT.
  - Load: go to LOAD.
  - SW: go to WRITE.
  - SB/SH: go to MERGE.
- Load extraction:
  - Byte lane = addr[1:0]; halfword lane = addr[1].
  - B/H: sign-extend. BU/HU: zero-extend. W: pass through.
- mem_Address = {latched_addr[31:2], 2'b00} in non-IDLE states; 0 in IDLE. Only bits [9:2] are decoded by the memory; upper bits pass through unchanged.
- mem_WE is high only in WRITE, so each store produces exactly one write.

## Timing
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_fault=0, mem_WE=0, mem_Address=0, mem_WD=0. All latched registers are 0.
- Latency from the accept edge to the resp_valid cycle:
  - Loads: 1 cycle.
  - SW: 1 cycle.
  - SB/SH: 2 cycles.
  - Faults: 1 cycle.
- Throughput: one outstanding request. req_ready=0 from the accept edge until the cycle after resp_valid. A back-to-back request is accepted on the edge that ends the resp_valid cycle only if state is IDLE at that edge; it is not, so the earliest next accept is one cycle after resp_valid.
- Response and memory outputs are combinational from state and latched registers. resp_rdata is stable for the whole LOAD cycle.
- MERGE reads and WRITE writes the same word. The memory is single-ported to this block, so no intervening writer exists.
- Reset asserted mid-operation returns immediately to IDLE and drops mem_WE. A store interrupted in MERGE or WRITE before the rising edge performs no write, and no response is issued.
- req_* changes while not ready are ignored.

## Configuration
- MISALIGN_TRAP_EN defined:
  - H/HU/SH with addr[0]=1 → FAULT.
  - W/SW with addr[1:0]≠0 → FAULT.
  - A misaligned store never writes memory.
- MISALIGN_TRAP_EN undefined:
  - Never faults on alignment.
  - Word accesses ignore addr[1:0].
  - Halfword accesses use addr[1] and ignore addr[0].
  - Invalid-funct3 faults remain.

## Test plan
- Reset, then SW addr 0x10 data 0xDEADBEEF → resp_valid 1 cycle after accept, mem_WE=1 with mem_Address=0x10 in that cycle. Then LW 0x10 → resp_rdata=0xDEADBEEF.
- With word 0x10 = 0xDEADBEEF: LB 0x13 → 0xFFFFFFDE; LBU 0x13 → 0x000000DE; LH 0x12 → 0xFFFFDEAD; LHU 0x10 → 0x0000BEEF.
- SB 0x11 data 0x55 over 0xDEADBEEF → single write of 0xDEAD55EF, 2 cycles after accept. SH 0x12 data 0x1234 → 0x123455EF.
- funct3=011 load, and LBU-encoded store → resp_fault=1 after 1 cycle, mem_WE never asserted.
- Misaligned SW 0x11 data 0x0:
  - With MISALIGN_TRAP_EN: fault, word 0x10 unchanged.
  - Without: writes 0x0 to word 0x10, no fault.
- Assert reset during the MERGE cycle of SB 0x10 → no write, no resp_valid, req_ready=1 after release, word 0x10 unchanged.

Source files
------------

// File: rtl/lsu_mem_port.sv
// Load/store unit bridging the core memory stage to a word-only 256x32 data memory.
// Byte/halfword stores use read-modify-write; define MISALIGN_TRAP_EN to fault on misaligned H/W accesses.
module lsu_mem_port (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_fault_o,
  output logic        mem_WE_o,
  output logic [31:0] mem_Address_o,
  output logic [31:0] mem_WD_o,
  input  logic [31:0] mem_RD_i
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MERGE, S_WRITE, S_FAULT} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, wdata_q, merged_q, merged_d, ld_data, rd_shift;
  logic [2:0]  f3_q;
  logic        accept, f3_bad, misalign;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign accept = req_valid_i && (state_q == S_IDLE);

  // Unsigned variants only exist for loads; 011 and 11x are unused encodings.
  assign f3_bad = (req_funct3_i == 3'b011) || (req_funct3_i[2:1] == 2'b11) ||
                  (req_funct3_i[2] && req_we_i);

`ifdef MISALIGN_TRAP_EN
  assign misalign = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                    ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (f3_bad || misalign)               state_d = S_FAULT;
          else if (!req_we_i)                   state_d = S_LOAD;
          else if (req_funct3_i[1:0] == 2'b10)  state_d = S_WRITE;
          else                                  state_d = S_MERGE;
        end
      end
      S_MERGE: state_d = S_WRITE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      f3_q     <= '0;
      merged_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        f3_q    <= req_funct3_i;
      end
      if (state_q == S_MERGE) merged_q <= merged_d;
    end
  end

  // Load extraction from the latched word.
  always_comb begin
    rd_shift = mem_RD_i >> {addr_q[1:0], 3'b000};
    ld_byte  = rd_shift[7:0];
    ld_half  = addr_q[1] ? mem_RD_i[31:16] : mem_RD_i[15:0];
    case (f3_q[1:0])
      2'b00:   ld_data = {{24{~f3_q[2] & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{16{~f3_q[2] & ld_half[15]}}, ld_half};
      default: ld_data = mem_RD_i;
    endcase
  end

  always_comb begin
    merged_d = mem_RD_i;
    if (f3_q[1:0] == 2'b00) merged_d[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else                    merged_d[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  always_comb begin
    req_ready_o   = (state_q == S_IDLE);
    resp_valid_o  = 1'b0;
    resp_rdata_o  = '0;
    resp_fault_o  = 1'b0;
    mem_WE_o      = 1'b0;
    mem_WD_o      = '0;
    mem_Address_o = (state_q == S_IDLE) ? 32'h0 : {addr_q[31:2], 2'b00};
    case (state_q)
      S_LOAD: begin
        resp_valid_o = 1'b1;
        resp_rdata_o = ld_data;
      end
      S_WRITE: begin
        resp_valid_o = 1'b1;
        mem_WE_o     = 1'b1;
        mem_WD_o     = (f3_q[1:0] == 2'b10) ? wdata_q : merged_q;
      end
      S_FAULT: begin
        resp_valid_o = 1'b1;
        resp_fault_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed table-driven bench for lsu_mem_port with a behavioural 256x32 memory.
module tb_lsu_mem_port;

  logic        clk = 1'b0, rst = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        resp_valid, resp_fault, mem_WE;
  logic [31:0] resp_rdata, mem_Address, mem_WD, mem_RD;

  logic [31:0] mem [256];
  int          wr_cnt = 0;
  int          errors = 0, checks = 0;

  always #5 clk = ~clk;

  lsu_mem_port dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_fault_o(resp_fault),
    .mem_WE_o(mem_WE), .mem_Address_o(mem_Address), .mem_WD_o(mem_WD), .mem_RD_i(mem_RD)
  );

  assign mem_RD = mem[mem_Address[9:2]];

  always @(posedge clk) begin
    if (mem_WE) begin
      mem[mem_Address[9:2]] <= mem_WD;
      wr_cnt++;
    end
  end

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        fault;
    int          lat;
    logic        wr;
    logic [31:0] wd;
  } vec_t;

  vec_t vt[24];
  int   nv = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                     input logic fault, input int lat, input logic wr, input logic [31:0] wd);
    vt[nv] = '{name, we, f3, addr, wdata, rdata, fault, lat, wr, wd};
    nv++;
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic run_vec(input vec_t t);
    int  w0, lat;
    bit  got;
    w0  = wr_cnt;
    lat = 0;
    got = 0;
    req_valid = 1'b1; req_we = t.we; req_funct3 = t.f3; req_addr = t.addr; req_wdata = t.wdata;
    @(posedge clk);
    #1;
    // Garbage while busy must be ignored.
    req_addr = 32'hFFFF_FFFF; req_wdata = 32'hA5A5_A5A5;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = i;
        got = 1;
        break;
      end
      chk({t.name, ".idle_rdata"}, resp_rdata, 32'h0);
      chk({t.name, ".early_we"}, {31'b0, mem_WE}, 32'h0);
    end
    req_valid = 1'b0;
    if (!got) begin
      errors++;
      checks++;
      $display("FAIL %s.timeout: no resp_valid within 5 cycles", t.name);
    end else begin
      chk({t.name, ".lat"}, lat, t.lat);
      chk({t.name, ".fault"}, {31'b0, resp_fault}, {31'b0, t.fault});
      chk({t.name, ".rdata"}, resp_rdata, t.rdata);
      chk({t.name, ".we"}, {31'b0, mem_WE}, {31'b0, t.wr});
      chk({t.name, ".addr"}, mem_Address, {t.addr[31:2], 2'b00});
      if (t.wr) chk({t.name, ".wd"}, mem_WD, t.wd);
      chk({t.name, ".busy"}, {31'b0, req_ready}, 32'h0);
    end
    @(negedge clk);
    chk({t.name, ".ready"}, {31'b0, req_ready}, 32'h1);
    chk({t.name, ".nwr"}, wr_cnt - w0, t.wr ? 1 : 0);
  endtask

  logic [31:0] w10;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;

    add("sw10",  1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        0, 1, 1, 32'hDEADBEEF);
    add("lw10",  0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 0, 1, 0, 32'h0);
    add("lb13",  0, 3'b000, 32'h13, 32'h0,        32'hFFFFFFDE, 0, 1, 0, 32'h0);
    add("lbu13", 0, 3'b100, 32'h13, 32'h0,        32'h000000DE, 0, 1, 0, 32'h0);
    add("lh12",  0, 3'b001, 32'h12, 32'h0,        32'hFFFFDEAD, 0, 1, 0, 32'h0);
    add("lhu10", 0, 3'b101, 32'h10, 32'h0,        32'h0000BEEF, 0, 1, 0, 32'h0);
    add("sb11",  1, 3'b000, 32'h11, 32'h55,       32'h0,        0, 2, 1, 32'hDEAD55EF);
    add("sh12",  1, 3'b001, 32'h12, 32'h1234,     32'h0,        0, 2, 1, 32'h123455EF);
    add("lw10b", 0, 3'b010, 32'h10, 32'h0,        32'h123455EF, 0, 1, 0, 32'h0);
    add("lb11",  0, 3'b000, 32'h11, 32'h0,        32'h00000055, 0, 1, 0, 32'h0);
    add("f3_011",0, 3'b011, 32'h10, 32'h0,        32'h0,        1, 1, 0, 32'h0);
    add("sbu",   1, 3'b100, 32'h10, 32'hFF,       32'h0,        1, 1, 0, 32'h0);
    add("f3_110",1, 3'b110, 32'h10, 32'hFF,       32'h0,        1, 1, 0, 32'h0);
`ifdef MISALIGN_TRAP_EN
    add("lh11",  0, 3'b001, 32'h11, 32'h0,        32'h0,        1, 1, 0, 32'h0);
    add("sw11",  1, 3'b010, 32'h11, 32'h0,        32'h0,        1, 1, 0, 32'h0);
    add("lw10c", 0, 3'b010, 32'h10, 32'h0,        32'h123455EF, 0, 1, 0, 32'h0);
    w10 = 32'h123455EF;
`else
    add("lh11",  0, 3'b001, 32'h11, 32'h0,        32'h000055EF, 0, 1, 0, 32'h0);
    add("sw11",  1, 3'b010, 32'h11, 32'h0,        32'h0,        0, 1, 1, 32'h0);
    add("lw10c", 0, 3'b010, 32'h10, 32'h0,        32'h0,        0, 1, 0, 32'h0);
    w10 = 32'h0;
`endif
    add("sb23",  1, 3'b000, 32'h23, 32'hAAAAAA80, 32'h0,        0, 2, 1, 32'h80000000);
    add("sh20",  1, 3'b001, 32'h20, 32'hFFFF5678, 32'h0,        0, 2, 1, 32'h80005678);
    add("lb23",  0, 3'b000, 32'h23, 32'h0,        32'hFFFFFF80, 0, 1, 0, 32'h0);
    add("lh22",  0, 3'b001, 32'h22, 32'h0,        32'hFFFF8000, 0, 1, 0, 32'h0);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.ready", {31'b0, req_ready}, 32'h1);
    chk("rst.valid", {31'b0, resp_valid}, 32'h0);
    chk("rst.rdata", resp_rdata, 32'h0);
    chk("rst.fault", {31'b0, resp_fault}, 32'h0);
    chk("rst.we", {31'b0, mem_WE}, 32'h0);
    chk("rst.addr", mem_Address, 32'h0);
    chk("rst.wd", mem_WD, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < nv; i++) run_vec(vt[i]);

    // Reset during the MERGE cycle of SB 0x10: no write, no response.
    begin
      int w0;
      w0 = wr_cnt;
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h10; req_wdata = 32'h99;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("mrst.merge_busy", {31'b0, req_ready}, 32'h0);
      chk("mrst.merge_valid", {31'b0, resp_valid}, 32'h0);
      chk("mrst.merge_addr", mem_Address, 32'h10);
      #1 rst = 1'b1;
      #1;
      chk("mrst.ready", {31'b0, req_ready}, 32'h1);
      chk("mrst.we", {31'b0, mem_WE}, 32'h0);
      chk("mrst.addr", mem_Address, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("mrst.novalid", {31'b0, resp_valid}, 32'h0);
        chk("mrst.ready_after", {31'b0, req_ready}, 32'h1);
      end
      chk("mrst.nwr", wr_cnt - w0, 0);
      chk("mrst.mem10", mem[4], w10);
    end
    run_vec('{"lw10d", 1'b0, 3'b010, 32'h10, 32'h0, w10, 1'b0, 1, 1'b0, 32'h0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
